regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  req0 = ALU/execute result, req1 = load data from memory. Drives the

---
 rtl/regfile_write_arbiter_pkg.sv | 29 ++
 rtl/regfile_write_arbiter_rr.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 78 +++++++
 tb/tb_regfile_write_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, request record and round-robin pick helper for the
// register-file write arbiter.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    // One pending register-file write as presented by a writeback source.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Two-way round-robin pick: a lone requester always wins; on contention
    // the source named by rrPtr wins. Result is one-hot (or zero).
    function automatic logic [1:0] rrPick(input logic [1:0] req, input logic rrPtr);
        logic [1:0] pick;
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = rrPtr ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin arbiter. Owns the fairness pointer; grants are
// combinational and suppressed while hold or reset is asserted.
module rr_arbiter_2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rrPtr;

    // Grant decision for this cycle; nothing is granted while frozen.
    always_comb begin
        gnt = 2'b00;
        if (!reset && !hold) begin
            gnt = rrPick(req, rrPtr);
        end
    end

    // Favour the source that lost (or did not win) the most recent grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr <= 1'b0;
        end else if (|gnt) begin
            rrPtr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the execute result
// (source 0) and load data (source 1). Writes to the zero register are
// acknowledged immediately and dropped without using the port.
module regfile_write_arbiter #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              grant_src
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              zeroHit0;
    logic              zeroHit1;
    logic [1:0]        portReq;
    logic [1:0]        gnt;
    logic              issueVld_p0;
    logic [ADDR_W-1:0] selAddr_p0;
    logic [DATA_W-1:0] selData_p0;

    // Zero-register writes bypass arbitration; only real writes compete.
    always_comb begin
        zeroHit0 = req0_valid && (req0_addr == ZERO_ADDR);
        zeroHit1 = req1_valid && (req1_addr == ZERO_ADDR);
        portReq  = {req1_valid && !zeroHit1, req0_valid && !zeroHit0};
    end

    rr_arbiter_2 uArb (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .req   (portReq),
        .gnt   (gnt)
    );

    // Ready = discarded zero-reg write or port grant; nothing accepted in reset.
    always_comb begin
        req0_ready  = !reset && (zeroHit0 || gnt[0]);
        req1_ready  = !reset && (zeroHit1 || gnt[1]);
        issueVld_p0 = |gnt;
        selAddr_p0  = gnt[1] ? req1_addr : req0_addr;
        selData_p0  = gnt[1] ? req1_data : req0_data;
    end

    // ---- stage p0 -> register-file port ----
    // Register the granted write; address/data/source hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            grant_src     <= 1'b0;
        end else begin
            RegWrite <= issueVld_p0;
            if (issueVld_p0) begin
                WriteRegister <= selAddr_p0;
                WriteData     <= selData_p0;
                grant_src     <= gnt[1];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: an independent arbitration
// model predicts readys and queues expected writes, which are popped and
// compared when the register-file port shows them.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    typedef struct {
        logic    src;
        wr_req_t req;
    } expWr_t;

    logic              clk;
    logic              reset;
    logic              hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              grant_src;

    regfile_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .req0_valid    (req0_valid),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .grant_src     (grant_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nVec = 0;
    int          nErr = 0;
    expWr_t      expQ[$];
    logic        mPtr = 1'b0;
    logic [4:0]  lastA = '0;
    logic [63:0] lastD = '0;
    logic        lastS = 1'b0;
    logic        lastR0 = 1'b0;
    logic        lastR1 = 1'b0;
    logic [63:0] regFile [32];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
        nVec++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One clock: model readys/grants for the inputs currently driven, then
    // check the port after the edge.
    task automatic step();
        logic   z0, z1, n0, n1, g0, g1;
        expWr_t e;
        @(negedge clk);
        #1;
        z0 = req0_valid && (req0_addr == 5'd31);
        z1 = req1_valid && (req1_addr == 5'd31);
        n0 = req0_valid && !z0;
        n1 = req1_valid && !z1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset && !hold) begin
            if (n0 && n1) begin
                if (mPtr) g1 = 1'b1; else g0 = 1'b1;
            end else if (n0) begin
                g0 = 1'b1;
            end else if (n1) begin
                g1 = 1'b1;
            end
        end
        lastR0 = !reset && (z0 || g0);
        lastR1 = !reset && (z1 || g1);
        checkVal("req0_ready", 64'(req0_ready), 64'(lastR0));
        checkVal("req1_ready", 64'(req1_ready), 64'(lastR1));
        if (g0) expQ.push_back('{src: 1'b0, req: '{addr: req0_addr, data: req0_data}});
        if (g1) expQ.push_back('{src: 1'b1, req: '{addr: req1_addr, data: req1_data}});
        @(posedge clk);
        #1;
        if (RegWrite === 1'b1) regFile[WriteRegister] = WriteData;
        if (reset) begin
            expQ.delete();
            mPtr  = 1'b0;
            lastA = '0;
            lastD = '0;
            lastS = 1'b0;
            checkVal("rst_RegWrite", 64'(RegWrite), 64'd0);
            checkVal("rst_WriteRegister", 64'(WriteRegister), 64'd0);
            checkVal("rst_WriteData", WriteData, 64'd0);
            checkVal("rst_grant_src", 64'(grant_src), 64'd0);
        end else if (g0 || g1) begin
            mPtr = g0;
            e = expQ.pop_front();
            lastA = e.req.addr;
            lastD = e.req.data;
            lastS = e.src;
            checkVal("RegWrite", 64'(RegWrite), 64'd1);
            checkVal("WriteRegister", 64'(WriteRegister), 64'(e.req.addr));
            checkVal("WriteData", WriteData, e.req.data);
            checkVal("grant_src", 64'(grant_src), 64'(e.src));
        end else begin
            checkVal("idle_RegWrite", 64'(RegWrite), 64'd0);
            checkVal("idle_WriteRegister", 64'(WriteRegister), 64'(lastA));
            checkVal("idle_WriteData", WriteData, lastD);
            checkVal("idle_grant_src", 64'(grant_src), 64'(lastS));
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic h, input logic r);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        hold = h; reset = r;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regFile[i] = '0;
        drive(1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66, 1'b0, 1'b1);

        // Reset held two cycles with both sources valid, then req0 wins first.
        step();
        step();
        drive(1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66, 1'b0, 1'b0);
        step();
        checkVal("t1_first_src", 64'(grant_src), 64'd0);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h66, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();

        // Single req0 write: one-cycle latency, one-cycle strobe.
        drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();
        checkVal("t2_reg", 64'(WriteRegister), 64'd5);
        checkVal("t2_data", WriteData, 64'hAA);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();
        checkVal("t2_strobe_drop", 64'(RegWrite), 64'd0);

        // req1 alone brings the pointer back to source 0.
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd8, 64'h88, 1'b0, 1'b0);
        step();

        // Continuous contention: alternating grants 0,1,0,1.
        drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'h77, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkVal("t3_alt_src", 64'(grant_src), 64'(i % 2));
            checkVal("t3_alt_reg", 64'(WriteRegister), (i % 2) ? 64'd7 : 64'd3);
        end
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();

        // Zero-register write acknowledged under hold without a port write.
        drive(1'b1, 5'd2, 64'h22, 1'b1, 5'd31, 64'hFF, 1'b1, 1'b0);
        step();
        checkVal("t4_zero_ready", 64'(lastR1), 64'd1);
        drive(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();
        checkVal("t4_after_hold", 64'(WriteRegister), 64'd2);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();

        // Same destination from both sources with pointer on source 1.
        drive(1'b1, 5'd9, 64'h1, 1'b1, 5'd9, 64'h2, 1'b0, 1'b0);
        step();
        checkVal("t5_first_data", WriteData, 64'h2);
        drive(1'b1, 5'd9, 64'h1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();
        checkVal("t5_second_data", WriteData, 64'h1);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();
        checkVal("t5_reg9_final", regFile[9], 64'h1);

        // Reset right after a grant drops the issued write and the pointer.
        drive(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd12, 64'hC1, 1'b1, 5'd13, 64'hD0, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'd12, 64'hC1, 1'b1, 5'd13, 64'hD0, 1'b0, 1'b0);
        step();
        checkVal("t6_ptr_reset_src", 64'(grant_src), 64'd0);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd13, 64'hD0, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
        step();

        // Random traffic honouring the hold-while-not-ready rule.
        for (int i = 0; i < 300; i++) begin
            if (!(req0_valid && !lastR0)) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_addr  = 5'($urandom_range(0, 31));
                req0_data  = {$urandom, $urandom};
            end
            if (!(req1_valid && !lastR1)) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_addr  = 5'($urandom_range(0, 31));
                req1_data  = {$urandom, $urandom};
            end
            hold = ($urandom_range(0, 7) == 0);
            step();
        end
        checkVal("zero_reg_untouched", regFile[31], 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
